// File: rtl/vga_bounce_renderer.sv
// vga_bounce_renderer: bouncing square ball over a checkerboard, 1-cycle registered RGB.
// Define VGA_BORDER_EN to add a 4-pixel red frame around the visible area.
module vga_bounce_renderer #(
  parameter int BALL_SIZE = 16,
  parameter int STEP = 2,
  parameter int INIT_X = 100,
  parameter int INIT_Y = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] CounterX,
  input  logic [8:0] CounterY,
  input  logic       inDisplayArea,
  input  logic       pause,
  output logic       vga_R,
  output logic       vga_G,
  output logic       vga_B,
  output logic [7:0] bounce_count,
  output logic       paused
);
  typedef enum logic {RUN, PAUSED} state_t;
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  localparam logic [10:0] ST = 11'(STEP);
  state_t state_q;
  logic [9:0] ball_x_q, ball_x_d;
  logic [8:0] ball_y_q, ball_y_d;
  logic dir_x_q, dir_y_q, dir_x_d, dir_y_d;
  logic hit_x, hit_y, frame_tick, in_ball, border;
  logic [10:0] x_w, y_w, cx_w, cy_w;
  logic [2:0] rgb_d;
  assign x_w = {1'b0, ball_x_q};
  assign y_w = {2'b0, ball_y_q};
  assign cx_w = {1'b0, CounterX};
  assign cy_w = {2'b0, CounterY};
  assign frame_tick = (CounterX == 10'd767) && (CounterY == 9'd479);
  // dir 1 = left/up; bounces clamp to the wall instead of overshooting
  always_comb begin
    hit_x = dir_x_q ? (x_w <= ST) : (x_w + BS + ST >= 11'd640);
    hit_y = dir_y_q ? (y_w <= ST) : (y_w + BS + ST >= 11'd480);
    ball_x_d = 10'(hit_x ? (dir_x_q ? 11'd0 : 11'd640 - BS) : (dir_x_q ? x_w - ST : x_w + ST));
    ball_y_d = 9'(hit_y ? (dir_y_q ? 11'd0 : 11'd480 - BS) : (dir_y_q ? y_w - ST : y_w + ST));
    dir_x_d = dir_x_q ^ hit_x;
    dir_y_d = dir_y_q ^ hit_y;
    in_ball = (cx_w >= x_w) && (cx_w < x_w + BS) && (cy_w >= y_w) && (cy_w < y_w + BS);
    rgb_d = !inDisplayArea ? 3'b000 : in_ball ? 3'b111 : border ? 3'b100 : {2'b00, CounterX[5] ^ CounterY[5]};
  end
`ifdef VGA_BORDER_EN
  assign border = (CounterX < 10'd4) || (CounterX > 10'd635) || (CounterY < 9'd4) || (CounterY > 9'd475);
`else
  assign border = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {vga_R, vga_G, vga_B} <= 3'b000;
      bounce_count <= 8'd0;
      paused <= 1'b0;
      state_q <= RUN;
      ball_x_q <= 10'(INIT_X);
      ball_y_q <= 9'(INIT_Y);
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
    end else begin
      {vga_R, vga_G, vga_B} <= rgb_d;
      if (frame_tick) begin
        if (state_q == RUN && !pause) begin
          ball_x_q <= ball_x_d;
          ball_y_q <= ball_y_d;
          dir_x_q <= dir_x_d;
          dir_y_q <= dir_y_d;
          if (hit_x || hit_y) bounce_count <= bounce_count + 8'd1;
        end
        state_q <= pause ? PAUSED : RUN;
        paused <= pause;
      end
    end
  end
endmodule

// File: tb/tb_vga_bounce_renderer.sv
// tb_vga_bounce_renderer: vector table, corner/pause/reset sequences and random ticks vs a frame-level model.
module tb_vga_bounce_renderer;
  localparam int BS = 16;
  localparam int ST = 2;
`ifdef VGA_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif
  typedef struct {int x; int y; bit d; int rgb;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0, de = 1'b0, pause = 1'b0;
  logic [9:0] cx = '0;
  logic [8:0] cy = '0;
  logic r, g, b, cr, cg, cb, pd, cpd;
  logic [7:0] bc, cbc;
  int checks = 0, errors = 0;
  int mx, my, mdx, mdy, mp, mc, n_ticks;
  vec_t tbl[12];

  always #5 clk = ~clk;

  vga_bounce_renderer dut (
    .clk(clk), .rst_n(rst_n), .CounterX(cx), .CounterY(cy), .inDisplayArea(de), .pause(pause),
    .vga_R(r), .vga_G(g), .vga_B(b), .bounce_count(bc), .paused(pd)
  );
  vga_bounce_renderer #(.INIT_X(200), .INIT_Y(40)) dutc (
    .clk(clk), .rst_n(rst_n), .CounterX(cx), .CounterY(cy), .inDisplayArea(de), .pause(pause),
    .vga_R(cr), .vga_G(cg), .vga_B(cb), .bounce_count(cbc), .paused(cpd)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int x, input int y, input bit d);
    @(negedge clk);
    cx = 10'(x);
    cy = 9'(y);
    de = d;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_pix(input int x, input int y, input bit d);
    if (!d) return 0;
    if (x >= mx && x < mx + BS && y >= my && y < my + BS) return 7;
    if (BORDER && (x < 4 || x > 635 || y < 4 || y > 475)) return 4;
    return ((x >> 5) ^ (y >> 5)) & 1;
  endfunction

  task automatic probe(input int x, input int y, input bit d);
    cyc(x, y, d);
    chk($sformatf("pix(%0d,%0d,%0d)", x, y, d), {29'd0, r, g, b}, exp_pix(x, y, d));
  endtask

  task automatic model_reset();
    mx = 100; my = 60; mdx = 0; mdy = 0; mp = 0; mc = 0; n_ticks = 0;
  endtask

  function automatic void axis(inout int p, inout int d, input int lim, inout bit hit);
    if (d == 0) begin
      if (p + BS + ST >= lim) begin p = lim - BS; d = 1; hit = 1'b1; end
      else p += ST;
    end else begin
      if (p <= ST) begin p = 0; d = 0; hit = 1'b1; end
      else p -= ST;
    end
  endfunction

  task automatic tick(input bit p);
    bit hit;
    pause = p;
    cyc(767, 479, 0);
    n_ticks++;
    hit = 1'b0;
    if (mp != 0) mp = p;
    else if (p) mp = 1;
    else begin
      axis(mx, mdx, 640, hit);
      axis(my, mdy, 480, hit);
      if (hit) mc = (mc + 1) % 256;
    end
    chk("bounce_count", bc, mc);
    chk("paused", pd, mp);
  endtask

  task automatic check_ball();
    int offs[4] = '{-1, 0, BS - 1, BS};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (mx + offs[i] >= 0 && mx + offs[i] < 640 && my + offs[j] >= 0 && my + offs[j] < 480)
          probe(mx + offs[i], my + offs[j], 1'b1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int c0, x, y;
    tbl[0]  = '{100, 60, 1'b1, 7};
    tbl[1]  = '{115, 75, 1'b1, 7};
    tbl[2]  = '{99, 60, 1'b1, 0};
    tbl[3]  = '{116, 75, 1'b1, 1};
    tbl[4]  = '{100, 59, 1'b1, 0};
    tbl[5]  = '{100, 76, 1'b1, 1};
    tbl[6]  = '{300, 200, 1'b0, 0};
    tbl[7]  = '{110, 70, 1'b0, 0};
    tbl[8]  = '{32, 10, 1'b1, 1};
    tbl[9]  = '{96, 32, 1'b1, 0};
    tbl[10] = '{2, 200, 1'b1, BORDER ? 4 : 0};
    tbl[11] = '{639, 479, 1'b1, BORDER ? 4 : 1};
    model_reset();
    rst_n = 1'b0;
    repeat (3) cyc(100, 60, 1'b1);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_count", bc, 0);
    chk("rst_paused", pd, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].x, tbl[i].y, tbl[i].d);
      chk($sformatf("vec%0d", i), {r, g, b}, tbl[i].rgb);
    end
    tick(1'b0);
    check_ball();
    cyc(117, 77, 1'b1);
    chk("white_117_77", {r, g, b}, 7);
    while (n_ticks < 211) tick(1'b0);
    chk("corner_pre", cbc, 0);
    tick(1'b0);
    chk("corner_once", cbc, 1);
    cyc(624, 464, 1'b1);
    chk("corner_pix", {cr, cg, cb}, 7);
    cyc(623, 463, 1'b1);
    chk("corner_bg", {cr, cg, cb}, 1);
    tick(1'b0);
    cyc(622, 462, 1'b1);
    chk("corner_back", {cr, cg, cb}, 7);
    chk("corner_stay", cbc, 1);
    for (int i = 0; i < 1000 && !(mx == 622 && mdx == 0); i++) tick(1'b0);
    chk("reach622", mx, 622);
    check_ball();
    c0 = mc;
    tick(1'b0);
    chk("bounce622", bc, (c0 + 1) % 256);
    check_ball();
    tick(1'b0);
    check_ball();
    tick(1'b1);
    repeat (3) begin
      pause = 1'b0;
      cyc(10, 10, 1'b0);
      tick(1'b1);
      check_ball();
    end
    tick(1'b0);
    check_ball();
    tick(1'b0);
    check_ball();
    repeat (300) begin
      tick($urandom_range(3) == 0);
      probe($urandom_range(639), $urandom_range(479), $urandom_range(1));
      x = mx - 1 + $urandom_range(BS + 1);
      y = my - 1 + $urandom_range(BS + 1);
      probe(x < 0 ? 0 : x > 639 ? 639 : x, y < 0 ? 0 : y > 479 ? 479 : y, 1'b1);
    end
    tick(1'b1);
    cyc(300, 200, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_rgb", {r, g, b}, 0);
    chk("midrst_count", bc, 0);
    chk("midrst_paused", pd, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pause = 1'b0;
    check_ball();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
